// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory port plus instruction hand-off to control/datapath
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instret;
  logic        fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, funct3, funct7_5,
           pc, pc_plus4, instret, fault,
    input  imem_rvalid, imem_rdata, instr_ready, PCSrc, PCTarget
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, funct3, funct7_5,
           pc, pc_plus4, instret, fault,
    output imem_rvalid, imem_rdata, instr_ready, PCSrc, PCTarget
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, one-word imem reads, held instruction with decode fields
// One instruction in flight; next PC is chosen when the held instruction is accepted.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_FAULT
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        fault_q, fault_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.instr_ready) begin
          instret_d = instret_q + 32'd1;
          // A misaligned target retires the instruction but freezes the PC for post-mortem.
          if (bus.PCSrc && (bus.PCTarget[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = bus.PCSrc ? bus.PCTarget : pc_plus4;
            state_d = S_FETCH;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_VALID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instret_q     <= 32'd0;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instret_q     <= instret_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[6:0];
  assign bus.funct3      = instr_q[14:12];
  assign bus.funct7_5    = instr_q[30];
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instret     = instret_q;
  assign bus.fault       = fault_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I single-core: owns the program counter, issues word reads to instruction memory, holds the fetched instruction and presents it with its decode fields (`op`, `funct3`, `funct7_5`) to the control unit and datapath. It consumes the control unit's `PCSrc` together with the datapath's branch/jump target to select the next PC when the current instruction is accepted.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: one-cycle read request pulse.
- `imem_addr` out 32: word address of the request, equal to `pc`.
- `imem_rvalid` in 1: read data valid, at least 1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, sampled when `imem_rvalid`=1 in WAIT.
- `instr_ready` in 1: downstream accepts the current instruction this cycle.
- `PCSrc` in 1: taken branch/jump for the current instruction, sampled with `instr_ready`.
- `PCTarget` in 32: next PC when `PCSrc`=1.
- `instr_valid` out 1: `instr` and its fields are valid.
- `instr` out 32: held instruction register.
- `op` out 7, `funct3` out 3, `funct7_5` out 1: `instr[6:0]`, `instr[14:12]`, `instr[30]`.
- `pc` out 32: address of `instr`.
- `pc_plus4` out 32: `pc + 4`, modulo 2^32.
- `instret` out 32: count of accepted instructions, wraps modulo 2^32.
- `fault` out 1: sticky misaligned-target fault.

## Operation
- States: BOOT, FETCH, WAIT, VALID, FAULT.
- Reset values: state BOOT, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `imem_req`=0, `instret`=0, `fault`=0.
- BOOT: `imem_req`=0; next state is always FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`; next state is always WAIT.
- WAIT: `imem_req`=0.
  - On `imem_rvalid`=1: `instr`<=`imem_rdata`, then go to VALID.
  - Otherwise stay in WAIT; there is no timeout.
- VALID: `instr_valid`=1, with `instr`, `pc` and fields stable.
  - `instr_ready`=0: hold.
  - `instr_ready`=1 and `PCSrc`=0: `pc`<=`pc_plus4`, `instret`++, go to FETCH.
  - `instr_ready`=1, `PCSrc`=1, `PCTarget[1:0]`=0: `pc`<=`PCTarget`, `instret`++, go to FETCH.
  - `instr_ready`=1, `PCSrc`=1, `PCTarget[1:0]`≠0: `pc` unchanged, `instret`++, `fault`<=1, go to FAULT.
- FAULT: `instr_valid`=0, `imem_req`=0, `fault`=1. Only `rst` leaves this state.
- Ignored inputs:
  - `imem_rvalid` outside WAIT (no capture, no state change).
  - `instr_ready` and `PCSrc` outside VALID.
- `pc_plus4` wraps: `pc`=32'hFFFF_FFFC gives 32'h0000_0000, and fetching continues.
- `rst` asserted in any state, including mid-WAIT, returns everything to reset values immediately. A late `imem_rvalid` arriving after reset (in BOOT or FETCH) is discarded.

## Timing
- Outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- First request is in the 2nd rising edge after `rst` deasserts (edge 1: BOOT→FETCH; `imem_req` high during the following cycle).
- Request-to-valid latency is k+1 cycles, where `imem_rvalid` arrives k≥1 cycles after `imem_req`. Minimum is 2.
- Accept-to-next-request is 1 cycle: `instr_ready` sampled in cycle t gives `imem_req` in cycle t+1.
- Peak throughput is one instruction per 3 cycles (FETCH, WAIT, VALID).
- `instret` and `pc` update on the same edge that samples `instr_ready`=1.

## Test plan
- Reset then sequential fetch, with `RESET_PC`=0 and memory latency 1, `instr_ready` held high:
  - `imem_addr` sequence is 0x0, 0x4, 0x8.
  - `imem_req` fires every 3 cycles.
  - `instret`=3 after the third accept.
- Stall: hold `instr_ready`=0 for 5 cycles in VALID → `instr`, `pc`, `instr_valid`=1 are unchanged and no `imem_req` is issued. On release, the next request is at `pc`+4.
- Taken branch: at `pc`=0x10 accept with `PCSrc`=1, `PCTarget`=0x40 → next `imem_addr`=0x40, and `op` matches the word returned from 0x40.
- Misaligned target: accept with `PCSrc`=1, `PCTarget`=0x42 → `fault`=1 and `instr_valid`=0 from the next cycle. `pc` keeps its old value and no further `imem_req` is issued. After `rst`, `fault`=0 and fetch restarts at `RESET_PC`.
- Memory latency 4 plus a spurious `imem_rvalid` in VALID → the instruction is captured only from WAIT, and the spurious data does not overwrite `instr`.
- Reset mid-WAIT, then stale `imem_rvalid` one cycle after deassert (data 0xDEADBEEF) → `instr` stays 0x0000_0013 and the first request goes to `RESET_PC`.
